div32x32_seq: RTL
=================

DIV32X32_SEQ -- requirements
Module: div32x32_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new division; sampled only in IDLE or DONE.
REQ-005 a  input  32  unsigned dividend; sampled on the edge that accepts start.
REQ-006 b  input  32  unsigned divisor; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while an iteration sequence is in progress (state CALC).
REQ-008 done  output  1  one-cycle pulse; results are valid in this cycle and after it.
REQ-009 quotient  output  32  a / b, registered.
REQ-010 remainder  output  32  a % b, registered.
REQ-011 div_by_zero  output  1  high with done when the accepted b was 0; holds until the next accepted start.

Function
REQ-012 FSM states SHALL be exactly IDLE, CALC and DONE.
REQ-013 IDLE: start=1 with b!=0 SHALL load the operands, clear the partial remainder, set the iteration counter to 31 and go to CALC.
REQ-014 IDLE: start=1 with b==0 SHALL go directly to DONE with quotient=32'hFFFFFFFF, remainder=a, div_by_zero=1.
REQ-015 CALC: each cycle SHALL perform one restoring step.
- Shift {rem, dividend_msb} left by one bit.
- Subtract the divisor.
- If the result is non-negative (33-bit compare, no overflow loss), commit the difference and shift 1 into the quotient; otherwise keep the value and shift in 0.
REQ-016 CALC SHALL last exactly 32 cycles (counter 31 down to 0); the edge at counter 0 SHALL go to DONE.
REQ-017 Latency: start accepted at edge k -> busy=1 in cycles k+1..k+32, done=1 in cycle k+33; divide-by-zero -> done in cycle k+1 and busy never asserted.
REQ-018 DONE SHALL last one cycle, then go to IDLE; start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back operation, done not repeated).
REQ-019 start during CALC SHALL be ignored; a and b changes during CALC SHALL NOT affect the result.
REQ-020 quotient, remainder and div_by_zero SHALL update only on completion (the CALC->DONE edge, or IDLE/DONE->DONE for divide-by-zero) and hold until the next completion.
REQ-021 busy and done SHALL be decoded from state only, never from start.
REQ-022 a<b SHALL yield quotient=0 and remainder=a; a=0 SHALL yield 0/0; no special-case latency other than b==0.

Reset
REQ-023 Asserting reset SHALL force state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, busy=0, done=0 immediately, including mid-CALC; the aborted operation produces no done.
REQ-024 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-025 Package div_pkg SHALL hold the state enum type (logic[1:0]: IDLE, CALC, DONE) and the localparam DIV_W=32.
REQ-026 Sub-module div_step SHALL be purely combinational.
- Inputs: rem_in[31:0], bit_in, divisor[31:0].
- Outputs: rem_out[31:0], q_bit.
REQ-027 The top level SHALL hold the FSM, the 5-bit counter and the operand, remainder and quotient registers.

Verification
REQ-028 a=100, b=7, start one cycle -> busy for 32 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0.
REQ-029 a=32'hFFFFFFFF, b=1 -> quotient=32'hFFFFFFFF, remainder=0; a=5, b=9 -> quotient=0, remainder=5.
REQ-030 a=1234, b=0 -> done on the next cycle, busy never high, quotient=32'hFFFFFFFF, remainder=1234, div_by_zero=1.
REQ-031 Start 100/7, then pulse start with a=9, b=3 at cycle 10 -> second request ignored; result is 14 r 2.
REQ-032 Assert reset at cycle 15 of CALC -> all outputs 0 at once; no done follows; a fresh 50/5 then returns 10 r 0.
REQ-033 Hold start=1 continuously with a new operand pair at each DONE -> operations run back to back, 33 cycles apart, each result correct against a reference model over 1000 random pairs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32/32 unsigned divider.
package div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W-1:0] diff;

  // Compare in DIV_W+1 bits so a carried-out MSB of the shifted remainder is not lost;
  // the committed difference always fits in DIV_W bits because rem_in < divisor.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    diff    = shifted[DIV_W-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/div32x32_seq.sv
// Sequential unsigned 32/32 divider: one restoring step per cycle, 32 cycles per result.
module div32x32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [4:0]       cnt;
  logic [DIV_W-1:0] dividend_r;
  logic [DIV_W-1:0] divisor_r;
  logic [DIV_W-1:0] rem_r;
  logic [DIV_W-1:0] rem_next;
  logic             q_bit;
  logic             accept;

  assign accept = start && (state != CALC);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  div_step u_step (
    .rem_in  (rem_r),
    .bit_in  (dividend_r[DIV_W-1]),
    .divisor (divisor_r),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (b == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= 5'd31;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state       <= DONE;
            quotient    <= {dividend_r[DIV_W-2:0], q_bit};
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The dividend register doubles as the quotient accumulator: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (accept && (b != '0)) begin
      dividend_r <= a;
      divisor_r  <= b;
      rem_r      <= '0;
    end else if (state == CALC) begin
      dividend_r <= {dividend_r[DIV_W-2:0], q_bit};
      rem_r      <= rem_next;
    end
  end

endmodule
